// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the Z80 CPU and the video fetch engine.
// Fixed two-cycle slots (ISSUE, CAPT); video has priority, CPU starvation is bounded by run_cnt.
module ram_arbiter #(
  parameter int ADDR_W      = 21,
  parameter int VID_MAX_RUN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_wait_n,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_ack,
  output logic [7:0]        o_vid_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_run_cnt
);

  // Handshake: req is a level sampled only when arbitrating (IDLE/CAPT); a granted access always
  // completes with a one-cycle ack, and a req still high the cycle after its ack starts a new access.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPT = 2'd2} state_t;

  localparam logic [3:0] RUN_MAX = 4'(VID_MAX_RUN);

  state_t     state, state_nx;
  logic       owner_cpu, owner_we;
  logic [3:0] run_cnt;
  logic       arb, cpu_elig, vid_elig, grant_cpu, grant_vid;

  always_comb begin
    arb       = (state != ISSUE);
    cpu_elig  = i_cpu_req & ~o_cpu_ack & ~((state == CAPT) & owner_cpu);
    vid_elig  = i_vid_req & ~o_vid_ack & ~((state == CAPT) & ~owner_cpu);
    grant_cpu = arb & cpu_elig & (~vid_elig | (run_cnt == RUN_MAX));
    grant_vid = arb & vid_elig & ~grant_cpu;
    state_nx  = state;
    case (state)
      IDLE:    if (grant_cpu | grant_vid) state_nx = ISSUE;
      ISSUE:   state_nx = CAPT;
      CAPT:    state_nx = (grant_cpu | grant_vid) ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      owner_cpu   <= 1'b0;
      owner_we    <= 1'b0;
      run_cnt     <= 4'd0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 8'h00;
      o_cpu_ack   <= 1'b0;
      o_vid_ack   <= 1'b0;
      o_cpu_rdata <= 8'h00;
      o_vid_rdata <= 8'h00;
    end else begin
      state     <= state_nx;
      o_cpu_ack <= 1'b0;
      o_vid_ack <= 1'b0;
      o_mem_en  <= grant_cpu | grant_vid;
      o_mem_we  <= grant_cpu & i_cpu_we;
      if (grant_cpu) begin
        o_mem_addr  <= i_cpu_addr;
        o_mem_wdata <= i_cpu_wdata;
        owner_cpu   <= 1'b1;
        owner_we    <= i_cpu_we;
        run_cnt     <= 4'd0;
      end else if (grant_vid) begin
        o_mem_addr <= i_vid_addr;
        owner_cpu  <= 1'b0;
        owner_we   <= 1'b0;
        if (run_cnt < RUN_MAX) run_cnt <= run_cnt + 4'd1;
      end
      // Completion uses the owner of the finishing slot; a new grant in CAPT overwrites it at the same edge.
      if (state == CAPT) begin
        if (owner_cpu) begin
          o_cpu_ack <= 1'b1;
          if (!owner_we) o_cpu_rdata <= i_mem_rdata;
        end else begin
          o_vid_ack   <= 1'b1;
          o_vid_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_cpu_wait_n = ~(i_cpu_req & ~o_cpu_ack);
  assign dbg_state    = state;
  assign dbg_run_cnt  = run_cnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a grant-schedule reference model with a small RAM model and read-data queues.
module tb_ram_arbiter;
  localparam int ADDR_W = 21;
  localparam int MAXR   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_wdata = 8'h00;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              cpu_ack, cpu_wait_n, vid_ack, mem_en, mem_we;
  logic [7:0]        cpu_rdata, vid_rdata, mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_run_cnt;

  ram_arbiter #(.ADDR_W(ADDR_W), .VID_MAX_RUN(MAXR)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_wait_n(cpu_wait_n),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_ack(vid_ack), .o_vid_rdata(vid_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_run_cnt(dbg_run_cnt)
  );

  // ---------------- clock / RAM array ----------------
  always #5 clk = ~clk;

  logic [7:0] ram_b[16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram_b[mem_addr[3:0]] <= mem_wdata;
      mem_rdata <= ram_b[mem_addr[3:0]];
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0, n_fail = 0, cyc = 0;
  int lg = -100, lcg = -100, lvg = -100, run_m = 0;
  logic lg_cpu = 1'b0, lg_we = 1'b0, lcg_we = 1'b0;
  logic [ADDR_W-1:0] lg_addr = '0;
  logic [7:0] lg_wdata = 8'h00, e_cpu_rdata = 8'h00, e_vid_rdata = 8'h00;
  logic [7:0] ram_m[16] = '{default: 8'h00};
  logic [7:0] cpu_exp_q[$], vid_exp_q[$];

  logic rand_mode = 1'b0;
  logic ack_prev_cpu = 1'b0, ack_cur_cpu = 1'b0, ack_prev_vid = 1'b0, ack_cur_vid = 1'b0;
  int pc = 0, kc = 0, pv = 0, kv = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    lg = -100; lcg = -100; lvg = -100; run_m = 0;
    lg_cpu = 1'b0; lg_we = 1'b0; lcg_we = 1'b0;
    e_cpu_rdata = 8'h00; e_vid_rdata = 8'h00;
    cpu_exp_q.delete(); vid_exp_q.delete();
  endtask

  task automatic model_cycle();
    logic e_issue, e_capt, e_cack, e_vack, e_wait, e_we, cel, vel, gc;
    if (!rst_n) begin
      e_wait = ~cpu_req;
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cpu_ack", 32'(cpu_ack), 0);
      check("rst_vid_ack", 32'(vid_ack), 0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 0);
      check("rst_vid_rdata", 32'(vid_rdata), 0);
      check("rst_run_cnt", 32'(dbg_run_cnt), 0);
      check("rst_state", 32'(dbg_state), 0);
      check("rst_wait_n", 32'(cpu_wait_n), 32'(e_wait));
      model_reset();
      return;
    end
    e_issue = (cyc == lg + 1);
    e_capt  = (cyc == lg + 2);
    e_cack  = (cyc == lcg + 3);
    e_vack  = (cyc == lvg + 3);
    e_we    = e_issue & lg_we;
    e_wait  = ~(cpu_req & ~e_cack);
    if (e_cack && !lcg_we && cpu_exp_q.size() > 0) e_cpu_rdata = cpu_exp_q.pop_front();
    if (e_vack && vid_exp_q.size() > 0) e_vid_rdata = vid_exp_q.pop_front();
    if (e_we) ram_m[lg_addr[3:0]] = lg_wdata;
    check("state", 32'(dbg_state), e_issue ? 1 : (e_capt ? 2 : 0));
    check("mem_en", 32'(mem_en), 32'(e_issue));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("cpu_ack", 32'(cpu_ack), 32'(e_cack));
    check("vid_ack", 32'(vid_ack), 32'(e_vack));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
    check("vid_rdata", 32'(vid_rdata), 32'(e_vid_rdata));
    check("run_cnt", 32'(dbg_run_cnt), run_m);
    check("wait_n", 32'(cpu_wait_n), 32'(e_wait));
    if (e_issue) check("mem_addr", 32'(mem_addr), 32'(lg_addr));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(lg_wdata));
    // Arbitration: no decision while a slot is in its ISSUE half.
    if (!e_issue) begin
      cel = cpu_req && !e_cack && !(e_capt && lg_cpu);
      vel = vid_req && !e_vack && !(e_capt && !lg_cpu);
      if (cel || vel) begin
        gc = cel && (!vel || run_m == MAXR);
        if (gc) begin
          lcg = cyc; lcg_we = cpu_we; run_m = 0;
          if (!cpu_we) cpu_exp_q.push_back(ram_m[cpu_addr[3:0]]);
          lg_addr = cpu_addr; lg_wdata = cpu_wdata; lg_we = cpu_we;
        end else begin
          lvg = cyc;
          if (run_m < MAXR) run_m++;
          vid_exp_q.push_back(ram_m[vid_addr[3:0]]);
          lg_addr = vid_addr; lg_we = 1'b0;
        end
        lg = cyc; lg_cpu = gc;
      end
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [ADDR_W-1:0] rand_addr();
    return {17'($urandom), 4'($urandom_range(0, 15))};
  endfunction

  task automatic rand_drive();
    if (!cpu_req) begin
      if ($urandom_range(0, 15) < pc) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      end
    end else if (ack_prev_cpu) begin
      if ($urandom_range(0, 15) >= kc) cpu_req = 1'b0;
      else begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      end
    end else if ($urandom_range(0, 63) == 0) cpu_req = 1'b0;
    if (!vid_req) begin
      if ($urandom_range(0, 15) < pv) begin
        vid_req = 1'b1; vid_addr = rand_addr();
      end
    end else if (ack_prev_vid) begin
      if ($urandom_range(0, 15) >= kv) vid_req = 1'b0;
      else vid_addr = rand_addr();
    end else if ($urandom_range(0, 63) == 0) vid_req = 1'b0;
  endtask

  // One cycle: check at the falling edge, then move inputs just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    model_cycle();
    @(posedge clk);
    #1;
    ack_prev_cpu = ack_cur_cpu; ack_cur_cpu = cpu_ack;
    ack_prev_vid = ack_cur_vid; ack_cur_vid = vid_ack;
    if (rand_mode) rand_drive();
  endtask

  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                            output int lat);
    logic got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(); lat++;
      if (cpu_ack) got = 1'b1;
    end
    check("cpu_ack_seen", 32'(got), 1);
    step();
    cpu_req = 1'b0;
  endtask

  initial begin
    int lat, vl, cl, n, acks, hold;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // CPU write, then read-back of the same location
    cpu_access(1'b1, 21'h1F_C000, 8'hA5, lat);
    check("wr_latency", lat, 3);
    repeat (2) step();
    cpu_access(1'b0, 21'h1F_C000, 8'h00, lat);
    check("rd_latency", lat, 3);
    check("rd_data", 32'(cpu_rdata), 32'h A5);
    repeat (3) step();

    // Simultaneous requests from IDLE: video first, CPU in video's CAPT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h0A_0003;
    vid_req = 1'b1; vid_addr = 21'h01_2345;
    vl = -1; cl = -1;
    for (n = 1; n <= 12; n++) begin
      step();
      if (ack_prev_vid) vid_req = 1'b0;
      if (ack_prev_cpu) cpu_req = 1'b0;
      if (ack_cur_vid && vl < 0) vl = n;
      if (ack_cur_cpu && cl < 0) cl = n;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    check("sim_vid_latency", vl, 3);
    check("sim_cpu_latency", cl, 5);
    repeat (3) step();

    // CPU holds req one cycle past its ack: exactly one extra access
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h1F_C007; cpu_wdata = 8'h3C;
    acks = 0; hold = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (cpu_ack) acks++;
      if (hold == 1) begin cpu_req = 1'b0; hold = 2; end
      else if (hold == 0 && ack_prev_cpu) hold = 1;
    end
    cpu_req = 1'b0;
    check("hold_ack_count", acks, 2);
    repeat (3) step();

    // Video held continuously with CPU continuously pending
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1F_C007;
    vid_req = 1'b1; vid_addr = 21'h00_0009;
    repeat (40) step();
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (6) step();

    // Reset during ISSUE of a CPU read drops it; next access is normal
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1F_C000;
    step();
    rst_n = 1'b0; cpu_req = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    cpu_access(1'b0, 21'h1F_C007, 8'h00, lat);
    check("post_rst_latency", lat, 3);
    repeat (3) step();

    // Randomized traffic phases
    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0: begin pc = 4;  kc = 4;  pv = 4;  kv = 4;  end
        1: begin pc = 16; kc = 16; pv = 16; kv = 16; end
        2: begin pc = 1;  kc = 0;  pv = 16; kv = 16; end
        3: begin pc = 12; kc = 8;  pv = 3;  kv = 4;  end
        default: begin pc = 8; kc = 6; pv = 8; kv = 12; end
      endcase
      rand_mode = 1'b1;
      repeat (300) step();
    end
    rand_mode = 1'b0;
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
